// File: rtl/orb_frame_feeder.sv
// Multi-channel frame-ROM reader: shared address, RD_LAT-compensated capture, FIFO-buffered ready/valid pixel stream.
// First pixel appears RD_LAT+1 cycles after the first read; reads pause whenever FIFO plus in-flight data would exceed FIFO_DEPTH.

// Generic synchronous FIFO, 0-cycle read (data at head); caller must not push when full or pop when empty.
module orb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic [PW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + PW'(1);
            if (rd_en) rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[PW-2:0]] <= wr_data;
    end

    assign rd_data = mem[rptr[PW-2:0]];
    assign count   = wptr - rptr;
    assign empty   = (count == '0);
endmodule

module orb_frame_feeder #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int NCH        = 2,
    parameter int DW         = 8,
    parameter int AW         = 19,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 8,
    localparam int XW        = $clog2(IMG_W),
    localparam int YW        = $clog2(IMG_H),
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              mode_cont,
    output logic              mem_en,
    output logic [AW-1:0]     mem_addr,
    input  logic [NCH*DW-1:0] mem_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [NCH*DW-1:0] pix_data,
    output logic [XW-1:0]     pix_x,
    output logic [YW-1:0]     pix_y,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(IMG_H - 1);

    if ((IMG_W * IMG_H) > (1 << AW)) begin : g_chk_aw
        $error("orb_frame_feeder: IMG_W*IMG_H does not fit in AW address bits");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_chk_lat
        $error("orb_frame_feeder: RD_LAT must be 1..4");
    end
    if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < RD_LAT + 2) begin : g_chk_depth
        $error("orb_frame_feeder: FIFO_DEPTH must be a power of two >= RD_LAT+2");
    end

    state_t            state;
    logic              cont_mode;
    logic              stop_req;
    logic [RD_LAT-1:0] pipe_vld;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     inflight_count;
    logic              fifo_empty;
    logic [NCH*DW-1:0] fifo_rd_data;
    logic              issue;
    logic              xfer;
    logic              last_xfer;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;

    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < RD_LAT; i++) inflight_count = inflight_count + CW'(pipe_vld[i]);
    end

    // Reserve a FIFO slot for every read still in flight so the tail write can never overflow.
    assign issue  = (state == RUN) &&
                    (({1'b0, fifo_count} + {1'b0, inflight_count}) < (CW + 1)'(FIFO_DEPTH));
    assign mem_en = issue;

    assign pix_valid = !fifo_empty;
    assign xfer      = pix_valid && pix_ready;
    // Only the final pixel of a draining frame leaves both the pipe and the FIFO empty.
    assign last_xfer = (state == DRAIN) && xfer && (inflight_count == '0) && (fifo_count == CW'(1));

    orb_fifo #(.W(NCH * DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (pipe_vld[RD_LAT-1]),
        .wr_data (mem_data),
        .rd_en   (xfer),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cont_mode <= 1'b0;
            stop_req  <= 1'b0;
            mem_addr  <= '0;
            done      <= 1'b0;
            pipe_vld  <= '0;
        end else begin
            done        <= last_xfer;
            pipe_vld[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        cont_mode <= mode_cont;
                        stop_req  <= 1'b0;
                        mem_addr  <= '0;
                    end
                end
                RUN: begin
                    if (stop) stop_req <= 1'b1;
                    if (issue) begin
                        if (mem_addr == LAST_ADDR) begin
                            mem_addr <= '0;
                            if (!cont_mode || stop_req || stop) state <= DRAIN;
                        end else begin
                            mem_addr <= mem_addr + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (inflight_count == '0 && fifo_empty) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
        end else if (xfer) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
            if (pix_eof) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign busy     = (state != IDLE);
    assign pix_data = pix_valid ? fifo_rd_data : '0;
    assign pix_x    = x;
    assign pix_y    = y;
    assign pix_sof  = pix_valid && (x == '0) && (y == '0);
    assign pix_eol  = pix_valid && (x == X_LAST);
    assign pix_eof  = pix_valid && (x == X_LAST) && (y == Y_LAST);
endmodule

// File: tb/tb_orb_frame_feeder.sv
// Bench for orb_frame_feeder: two lanes (RD_LAT=1 and RD_LAT=3) run the same directed scenarios against a pixel-stream model.
module tb_orb_frame_feeder;
    localparam int W = 4, H = 3, NPIX = 12, NCH = 2, DW = 8, AW = 4, DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;

    task automatic check(input int lane, input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL lane%0d %s: got %0h, expected %0h", lane, name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rom(input int ch, input int a);
        return DW'(((a * 7) + 3) ^ (ch * 90));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic              rst_n = 1'b1;
        logic              start = 1'b0, stop = 1'b0, mode_cont = 1'b0, pix_ready = 1'b1;
        logic              mem_en;
        logic [AW-1:0]     mem_addr;
        logic [NCH*DW-1:0] mem_data;
        logic              pix_valid;
        logic [NCH*DW-1:0] pix_data;
        logic [1:0]        pix_x, pix_y;
        logic              pix_sof, pix_eol, pix_eof, busy, done;
        logic [15:0]       frame_cnt;
        logic              fin = 1'b0;

        int          out_idx = 0, iss_idx = 0, exp_frames = 0, exp_total = 0;
        bit          exp_done = 0, prev_stall = 0;
        logic [22:0] prev_out;
        logic [AW-1:0] a_pipe [LAT];

        orb_frame_feeder #(.IMG_W(W), .IMG_H(H), .NCH(NCH), .DW(DW), .AW(AW),
                           .RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
            .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode_cont(mode_cont),
            .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
            .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
            .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
            .busy(busy), .done(done), .frame_cnt(frame_cnt)
        );

        // Synchronous ROM with LAT cycles from address to data.
        always @(posedge clk) begin
            if (mem_en) a_pipe[0] <= mem_addr;
            for (int i = 1; i < LAT; i++) a_pipe[i] <= a_pipe[i-1];
        end
        assign mem_data = {rom(1, int'(a_pipe[LAT-1])), rom(0, int'(a_pipe[LAT-1]))};

        // Model: reads must walk 0..NPIX-1 repeatedly; accepted pixels must be the ROM in raster order.
        always @(negedge clk) begin
            int i;
            if (!rst_n) begin
                check(g, "reset outputs", 64'({mem_en, mem_addr, pix_valid, pix_data, pix_x, pix_y, pix_sof,
                                               pix_eol, pix_eof, busy, done, frame_cnt}), 64'(0));
                out_idx = 0; iss_idx = 0; exp_frames = 0; exp_done = 0; prev_stall = 0;
            end else begin
                check(g, "frame_cnt", 64'(frame_cnt), 64'(16'(exp_frames)));
                check(g, "done", 64'(done), 64'(exp_done));
                exp_done = 0;
                check(g, "occupancy", 64'((int'(dut.fifo_count) + int'(dut.inflight_count)) <= DEPTH), 64'(1));
                if (mem_en) begin
                    check(g, "extra read", 64'(iss_idx < exp_total), 64'(1));
                    check(g, "mem_addr", 64'(mem_addr), 64'(iss_idx % NPIX));
                    iss_idx++;
                end
                if (prev_stall)
                    check(g, "stall hold", 64'({pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof}),
                          64'({1'b1, prev_out}));
                if (pix_valid && pix_ready) begin
                    i = out_idx % NPIX;
                    check(g, "pix_data", 64'(pix_data), 64'({rom(1, i), rom(0, i)}));
                    check(g, "x/y/markers", 64'({pix_x, pix_y, pix_sof, pix_eol, pix_eof}),
                          64'((i % W) * 32 + (i / W) * 8 + (i == 0) * 4 + ((i % W) == W - 1) * 2 + (i == NPIX - 1)));
                    out_idx++;
                    if (i == NPIX - 1) exp_frames++;
                    if (out_idx == exp_total) exp_done = 1;
                end
                prev_stall = pix_valid && !pix_ready;
                prev_out   = {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof};
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic pulse_start(input logic cont);
            mode_cont = cont; start = 1'b1;
            tick();
            start = 1'b0; mode_cont = 1'b0;
        endtask

        task automatic run_until_done(input bit rnd, input bit start_at_done, input string tag);
            int n;
            for (n = 0; n < 2000; n++) begin
                if (done) break;
                pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                tick();
            end
            check(g, {tag, " done seen"}, 64'(n < 2000), 64'(1));
            pix_ready = 1'b1;
            start = start_at_done;
            check(g, {tag, " busy in done cycle"}, 64'(busy), 64'(1));
            tick();
            start = 1'b0;
            check(g, {tag, " idle after done"}, 64'(busy), 64'(0));
        endtask

        initial begin
            int fe, fv, n;
            bit prev11;
            #1 rst_n = 1'b0;
            repeat (3) tick();
            rst_n = 1'b1;
            tick();
            check(g, "idle busy", 64'(busy), 64'(0));
            check(g, "idle mem_en", 64'(mem_en), 64'(0));

            // Single frame, ready always high: latency and first pixel literal.
            exp_total += NPIX; fe = -1; fv = -1;
            start = 1'b1; tick(); start = 1'b0;
            for (n = 0; n < 200 && !done; n++) begin
                if (mem_en && fe < 0) fe = n;
                if (pix_valid && fv < 0) begin
                    fv = n;
                    check(g, "first pixel", 64'({pix_data, pix_x, pix_y, pix_sof}), 64'({16'h5903, 5'b00001}));
                end
                tick();
            end
            check(g, "latency", 64'(fv - fe), 64'(LAT + 1));
            run_until_done(0, 0, "s1");
            check(g, "s1 frame_cnt", 64'(frame_cnt), 64'(1));
            check(g, "s1 reads", 64'(iss_idx), 64'(12));

            // Random 50% backpressure.
            exp_total += NPIX;
            pulse_start(1'b0);
            run_until_done(1, 0, "s2");
            check(g, "s2 frame_cnt", 64'(frame_cnt), 64'(2));

            // Ready held low: reads stop at FIFO_DEPTH, head pixel held.
            exp_total += NPIX; pix_ready = 1'b0;
            start = 1'b1; tick(); start = 1'b0;
            repeat (19) tick();
            check(g, "s3 reads while stalled", 64'(iss_idx - 24), 64'(8));
            check(g, "s3 mem_en stalled", 64'(mem_en), 64'(0));
            check(g, "s3 head held", 64'({pix_valid, pix_data}), 64'({1'b1, 16'h5903}));
            run_until_done(0, 0, "s3");
            check(g, "s3 frame_cnt", 64'(frame_cnt), 64'(3));

            // Continuous mode, stop during frame 3 at pixel 5.
            rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
            exp_total = 3 * NPIX; prev11 = 0;
            pulse_start(1'b1);
            for (n = 0; n < 500 && !done; n++) begin
                if (mem_en && (iss_idx == 12 || iss_idx == 24)) check(g, "b2b wrap", 64'(prev11), 64'(1));
                prev11 = mem_en && (mem_addr == 4'd11);
                stop = mem_en && (iss_idx == 29);
                tick();
            end
            stop = 1'b0;
            run_until_done(0, 0, "s4");
            check(g, "s4 frame_cnt", 64'(frame_cnt), 64'(3));
            check(g, "s4 reads", 64'(iss_idx), 64'(36));

            // Continuous mode, stop on the same cycle as the last-address read of frame 1.
            exp_total += NPIX;
            pulse_start(1'b1);
            for (n = 0; n < 500 && !done; n++) begin
                stop = mem_en && (iss_idx == 47);
                tick();
            end
            stop = 1'b0;
            run_until_done(0, 0, "s5");
            check(g, "s5 frame_cnt", 64'(frame_cnt), 64'(4));
            check(g, "s5 reads", 64'(iss_idx), 64'(48));

            // Reset at pixel 7, then a clean frame.
            exp_total += NPIX;
            pulse_start(1'b0);
            for (n = 0; n < 200 && out_idx != 55; n++) tick();
            check(g, "s6 reached pixel 7", 64'(out_idx), 64'(55));
            rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
            check(g, "s6 post-reset", 64'({busy, pix_valid, frame_cnt}), 64'(0));
            exp_total = NPIX;
            pulse_start(1'b0);
            run_until_done(0, 0, "s6");
            check(g, "s6 frame_cnt", 64'(frame_cnt), 64'(1));
            check(g, "s6 pixels", 64'(out_idx), 64'(12));

            // Stop while idle, start while busy and on the done cycle: all ignored.
            stop = 1'b1; tick(); stop = 1'b0;
            check(g, "s7 stop idle", 64'(busy), 64'(0));
            exp_total += NPIX;
            pulse_start(1'b0);
            repeat (5) tick();
            pulse_start(1'b1);
            run_until_done(0, 1, "s7");
            repeat (10) tick();
            check(g, "s7 stays idle", 64'({busy, frame_cnt}), 64'({1'b0, 16'd2}));
            check(g, "s7 reads", 64'(iss_idx), 64'(24));
            fin = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            if (lane[0].fin && lane[1].fin) break;
        end
        check(-1, "lanes finished", 64'(lane[0].fin && lane[1].fin), 64'(1));
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/orb_frame_feeder.md
Name:
orb_frame_feeder

Overview:
- Parametrised multi-channel image source feeding the ORB extractor from synchronous frame ROMs (stereo left/right by default).
- Generates a shared read address, compensates a configurable ROM read latency, and buffers returned pixels in a small FIFO.
- Presents a ready/valid pixel stream with x/y coordinates and frame markers.
- Supports single-shot and continuous (frame-wrapping) modes, graceful stop, and backpressure, none of which the current start-latch front end provides.

Parameters:
- IMG_W, 640, pixels per line.
- IMG_H, 480, lines per frame.
- NCH, 2, number of image channels read in lockstep.
- DW, 8, pixel width per channel.
- AW, 19, ROM address width; IMG_W*IMG_H <= 2^AW, enforced at elaboration.
- RD_LAT, 1, ROM address-to-data latency in cycles; legal range 1..4.
- FIFO_DEPTH, 8, output FIFO entries; power of two, >= RD_LAT+2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  level/pulse; starts operation when IDLE.
- stop  in  1  pulse; request to end after the current frame.
- mode_cont  in  1  1=continuous frames, 0=single frame; sampled at start.
- mem_en  out  1  ROM read enable (all channels).
- mem_addr  out  AW  ROM read address, shared by all channels.
- mem_data  in  NCH*DW  ROM data; channel k at bits [k*DW +: DW].
- pix_valid  out  1  output pixel available.
- pix_ready  in  1  downstream accepts.
- pix_data  out  NCH*DW  pixel of all channels.
- pix_x  out  $clog2(IMG_W)  column of pix_data.
- pix_y  out  $clog2(IMG_H)  row of pix_data.
- pix_sof  out  1  first pixel of frame (x=0,y=0).
- pix_eol  out  1  last pixel of line.
- pix_eof  out  1  last pixel of frame.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- frame_cnt  out  16  frames fully transferred; wraps at 65535->0.

Behaviour:
- Reset: all outputs 0, FIFO empty, in-flight pipe cleared, state IDLE, latched mode 0, stop_req 0.
- State machine (IDLE, RUN, DRAIN):
  - IDLE -> RUN when start=1: latch mode_cont, clear stop_req, set mem_addr=0.
  - RUN issues reads; on issuing address IMG_W*IMG_H-1:
    - mode_cont=1 and stop_req=0: wrap mem_addr to 0, stay in RUN, no idle cycle inserted.
    - otherwise: go to DRAIN.
  - DRAIN -> IDLE when in-flight=0, FIFO empty, and no transfer pending; done=1 for exactly the cycle after the last transfer.
- start while busy is ignored.
- stop in RUN sets stop_req; a stop pulse while IDLE is ignored. stop never truncates a frame.
- Issue rule:
  - issue = (state==RUN) && (fifo_count + inflight_count < FIFO_DEPTH).
  - mem_en = issue; mem_addr increments only on issue and holds otherwise.
- In-flight pipe: RD_LAT-stage valid shift register. At the tail, mem_data is written into the FIFO. Overflow is impossible by the issue rule; the bench asserts this.
- Output:
  - pix_valid = FIFO non-empty; transfer = pix_valid && pix_ready.
  - pix_data, pix_x, pix_y and markers are stable while pix_valid && !pix_ready.
  - Output latency from first mem_en to first pix_valid is RD_LAT+1 cycles.
- Coordinates: output-side x/y counters advance on transfer.
  - x wraps IMG_W-1 -> 0 and then y increments.
  - y wraps IMG_H-1 -> 0.
  - Markers are decoded combinationally from x/y and gated by pix_valid.
- frame_cnt increments on a transfer with pix_eof=1.
- Simultaneous events:
  - stop on the same cycle as the last-address issue: the frame ends (DRAIN).
  - start on the same cycle done=1: ignored, because the state is not yet IDLE.
- Reset mid-operation discards FIFO and in-flight data; frame_cnt returns to 0.
- Sizing: RTL 200-300 lines; FIFO pointers are $clog2(FIFO_DEPTH)+1 bits wide.

Test Plan:
- IMG_W=4, IMG_H=3, RD_LAT=1, pix_ready=1, mode_cont=0, start pulse:
  - mem_addr issues 0..11, then DRAIN.
  - 12 transfers with data = ROM contents.
  - pix_sof on transfer 0, pix_eol on x=3, pix_eof on transfer 11.
  - done pulse once, frame_cnt=1, busy=0.
- Same configuration with RD_LAT=3 and pix_ready random 50%:
  - pixel order and data are exact.
  - Outputs hold while stalled.
  - fifo_count+inflight never exceeds FIFO_DEPTH=8.
  - No overflow assertion fires.
- pix_ready=0 held for 20 cycles after start:
  - mem_en stops after 8 issues; pix_valid=1 with pix_data=ROM[0] held.
  - After release, all 12 pixels arrive in order.
- mode_cont=1, stop pulsed during frame 3 at pixel 5:
  - frames 1-3 complete back to back, with addr 11 followed directly by 0.
  - frame_cnt=3, then done, then IDLE.
- rst_n asserted mid-frame at pixel 7, released, then start:
  - outputs are 0 during reset.
  - The new frame begins at addr 0 with x=0, y=0, frame_cnt=0, and no stale data.
- start re-pulsed while busy, and stop pulsed while IDLE:
  - both have no effect.
  - The single frame completes with frame_cnt=1.
